// File: rtl/pga_gain_serializer.sv
// Loads the lock-in front-end PGA gain code over a write-only SPI mode-0 link.
// Optional post-load settle blanking is enabled by defining PGA_SETTLE_BLANK_EN.
module pga_gain_serializer #(
   parameter int GAIN_W     = 5,
   parameter int FRAME_W    = 8,
   parameter int CLK_DIV    = 4,
   parameter int CS_SETUP   = 2,
   parameter int SETTLE_CYC = 1000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [GAIN_W-1:0] gain_code,
   input  logic              force_update,
   output logic              pga_sclk,
   output logic              pga_mosi,
   output logic              pga_cs_n,
   output logic              busy,
   output logic [GAIN_W-1:0] gain_applied,
   output logic              update_done,
   output logic              settle_blank
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_SHIFT  = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
`ifdef PGA_SETTLE_BLANK_EN
   localparam logic [2:0] S_SETTLE = 3'd4;
   localparam int CNT_M1  = (2 * CLK_DIV > CS_SETUP) ? 2 * CLK_DIV : CS_SETUP;
   localparam int CNT_MAX = (SETTLE_CYC > CNT_M1) ? SETTLE_CYC : CNT_M1;
`else
   localparam int CNT_MAX = (2 * CLK_DIV > CS_SETUP) ? 2 * CLK_DIV : CS_SETUP;
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(2 * CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_FIRST  = BIT_W'(FRAME_W - 1);
`ifdef PGA_SETTLE_BLANK_EN
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
`endif

   // Parameter sanity, caught at elaboration.
   if (GAIN_W > FRAME_W) begin : g_bad_gain_w
      $error("pga_gain_serializer: GAIN_W must be <= FRAME_W");
   end
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("pga_gain_serializer: CLK_DIV must be >= 1");
   end
   if (CS_SETUP < 1) begin : g_bad_cs_setup
      $error("pga_gain_serializer: CS_SETUP must be >= 1");
   end
   if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("pga_gain_serializer: SETTLE_CYC must be >= 1");
   end

   logic [2:0]         state_q, state_d;
   logic [GAIN_W-1:0]  gain_q;
   logic [GAIN_W-1:0]  shadow_q, shadow_d;
   logic [GAIN_W-1:0]  applied_q, applied_d;
   logic               init_pend_q, init_pend_d;
   logic               force_pend_q, force_pend_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic               sclk_q, sclk_d;
   logic               mosi_q, mosi_d;
   logic               cs_n_q, cs_n_d;
   logic               done_q, done_d;
`ifdef PGA_SETTLE_BLANK_EN
   logic               blank_q, blank_d;
`endif

   logic [FRAME_W-1:0] frame_shadow;
   logic [BIT_W-1:0]   bit_nx;
   logic               frame_msb;
   logic               pending;

   assign frame_shadow = FRAME_W'(shadow_q);
   assign bit_nx       = bit_q - 1'b1;
   // The pad bits above the gain code are zero, so the MSB is only live when the code fills the frame.
   assign frame_msb    = (FRAME_W > GAIN_W) ? 1'b0 : gain_q[GAIN_W-1];
   assign pending      = init_pend_q | force_pend_q | (gain_q != applied_q);

   // Not reset: sampling continues through reset so the first frame after release
   // already carries the live code.
   always_ff @(posedge clk) begin
      gain_q <= gain_code;
   end

   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      applied_d    = applied_q;
      init_pend_d  = init_pend_q;
      force_pend_d = force_pend_q | force_update;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      sclk_d       = sclk_q;
      mosi_d       = mosi_q;
      cs_n_d       = cs_n_q;
      done_d       = 1'b0;
`ifdef PGA_SETTLE_BLANK_EN
      blank_d      = blank_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (pending) begin
               shadow_d     = gain_q;
               init_pend_d  = 1'b0;
               force_pend_d = force_update;
               cs_n_d       = 1'b0;
               mosi_d       = frame_msb;
               cnt_d        = '0;
               state_d      = S_SETUP;
`ifdef PGA_SETTLE_BLANK_EN
               blank_d      = 1'b1;
`endif
            end
         end

         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               bit_d   = BIT_FIRST;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Each bit: CLK_DIV cycles low (data already stable), then CLK_DIV high.
         S_SHIFT: begin
            if (cnt_q == LOW_LAST) begin
               sclk_d = 1'b1;
               cnt_d  = cnt_q + 1'b1;
            end else if (cnt_q == HIGH_LAST) begin
               sclk_d = 1'b0;
               cnt_d  = '0;
               if (bit_q == '0) begin
                  state_d = S_HOLD;
               end else begin
                  bit_d  = bit_nx;
                  mosi_d = frame_shadow[bit_nx];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_HOLD: begin
            if (cnt_q == SETUP_LAST) begin
               cs_n_d = 1'b1;
               mosi_d = 1'b0;
               cnt_d  = '0;
`ifdef PGA_SETTLE_BLANK_EN
               state_d = S_SETTLE;
`else
               applied_d = shadow_q;
               done_d    = 1'b1;
               state_d   = S_IDLE;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

`ifdef PGA_SETTLE_BLANK_EN
         // New requests stay pending until the PGA has settled.
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               applied_d = shadow_q;
               done_d    = 1'b1;
               blank_d   = 1'b0;
               cnt_d     = '0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif

         default: begin
            state_d = S_IDLE;
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         shadow_q     <= '0;
         applied_q    <= '0;
         init_pend_q  <= 1'b1;
         force_pend_q <= 1'b0;
         cnt_q        <= '0;
         bit_q        <= '0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         done_q       <= 1'b0;
`ifdef PGA_SETTLE_BLANK_EN
         blank_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         applied_q    <= applied_d;
         init_pend_q  <= init_pend_d;
         force_pend_q <= force_pend_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         cs_n_q       <= cs_n_d;
         done_q       <= done_d;
`ifdef PGA_SETTLE_BLANK_EN
         blank_q      <= blank_d;
`endif
      end
   end

   assign pga_sclk     = sclk_q;
   assign pga_mosi     = mosi_q;
   assign pga_cs_n     = cs_n_q;
   assign busy         = (state_q != S_IDLE);
   assign gain_applied = applied_q;
   assign update_done  = done_q;
`ifdef PGA_SETTLE_BLANK_EN
   assign settle_blank = blank_q;
`else
   assign settle_blank = 1'b0;
`endif

endmodule

// File: tb/tb_pga_gain_serializer.sv
// Directed bench for pga_gain_serializer: a negedge monitor decodes frames off the
// serial pins; a linear stimulus sequence checks them against hand-computed values.
module tb_pga_gain_serializer;

`ifdef PGA_SETTLE_BLANK_EN
   localparam int SETTLE    = 10;
   localparam int GAP       = 11;
   localparam int LAG       = 10;
   localparam int BLANK_MID = 1;
`else
   localparam int SETTLE    = 1000;
   localparam int GAP       = 1;
   localparam int LAG       = 0;
   localparam int BLANK_MID = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] gain_code;
   logic       force_update;
   logic       pga_sclk, pga_mosi, pga_cs_n, busy, update_done, settle_blank;
   logic [4:0] gain_applied;

   int checks = 0;
   int errors = 0;

   pga_gain_serializer #(
      .GAIN_W(5), .FRAME_W(8), .CLK_DIV(4), .CS_SETUP(2), .SETTLE_CYC(SETTLE)
   ) dut (
      .clk(clk), .reset_n(reset_n), .gain_code(gain_code), .force_update(force_update),
      .pga_sclk(pga_sclk), .pga_mosi(pga_mosi), .pga_cs_n(pga_cs_n), .busy(busy),
      .gain_applied(gain_applied), .update_done(update_done), .settle_blank(settle_blank)
   );

   always #5 clk = ~clk;

   // Link monitor: everything sampled on the falling edge.
   logic       sclk_p = 1'b0;
   logic       cs_p = 1'b1;
   logic [7:0] rx = '0;
   int         rx_bits = 0;
   int         cs_low = 0;
   int         cs_high = 0;
   int         since_rise = 0;
   int         blank_run = 0;
   int         ud_cnt = 0;
   logic [7:0] frames[$];
   int         nbits[$];
   int         lows[$];
   int         gaps[$];
   int         lags[$];
   int         blanks[$];

   always @(negedge clk) begin
      sclk_p <= pga_sclk;
      cs_p   <= pga_cs_n;
      if (!reset_n) begin
         rx_bits   <= 0;
         cs_low    <= 0;
         cs_high   <= 0;
         blank_run <= 0;
      end else begin
         ud_cnt     <= ud_cnt + (update_done ? 1 : 0);
         since_rise <= since_rise + 1;
         if (pga_sclk && !sclk_p) begin
            rx      <= {rx[6:0], pga_mosi};
            rx_bits <= rx_bits + 1;
         end
         if (!pga_cs_n) cs_low <= cs_low + 1;
         else cs_high <= cs_high + 1;
         if (!pga_cs_n && cs_p) begin
            gaps.push_back(cs_high);
            cs_high <= 0;
            cs_low  <= 1;
            rx_bits <= 0;
         end
         if (pga_cs_n && !cs_p) begin
            frames.push_back(rx);
            nbits.push_back(rx_bits);
            lows.push_back(cs_low);
            since_rise <= 1;
            cs_high    <= 1;
            cs_low     <= 0;
         end
         if (update_done) lags.push_back((pga_cs_n && !cs_p) ? 0 : since_rise);
         if (settle_blank) blank_run <= blank_run + 1;
         else if (blank_run != 0) begin
            blanks.push_back(blank_run);
            blank_run <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_frames(input string tag, input int n, input int budget);
      int k = 0;
      while (frames.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      chk(tag, (frames.size() >= n) ? 1 : 0, 1);
   endtask

   int f0, ud0;

   initial begin
      reset_n = 1'b0; gain_code = 5'h00; force_update = 1'b0;
      tick(3);
      chk("rst_sclk",    pga_sclk, 0);
      chk("rst_mosi",    pga_mosi, 0);
      chk("rst_cs_n",    pga_cs_n, 1);
      chk("rst_busy",    busy, 0);
      chk("rst_applied", gain_applied, 0);
      chk("rst_done",    update_done, 0);
      chk("rst_blank",   settle_blank, 0);

      // 1: init frame with code 0
      reset_n = 1'b1;
      wait_frames("t1_timeout", 1, 300);
      tick(60);
      chk("t1_count",   frames.size(), 1);
      chk("t1_frame",   frames[0], 8'h00);
      chk("t1_bits",    nbits[0], 8);
      chk("t1_cs_low",  lows[0], 68);
      chk("t1_applied", gain_applied, 5'h00);
      chk("t1_done",    ud_cnt, 1);
      chk("t1_lag",     lags[0], LAG);
      chk("t1_busy",    busy, 0);

      // 2+3: 0x13 frame, then 0x05 and 0x1F mid-frame; 0x05 must be dropped
      f0 = frames.size(); ud0 = ud_cnt;
      gain_code = 5'h13;
      tick(25);
      chk("t3_busy_mid",    busy, 1);
      chk("t3_applied_mid", gain_applied, 5'h00);
      chk("t3_blank_mid",   settle_blank, BLANK_MID);
      gain_code = 5'h05;
      tick(10);
      gain_code = 5'h1F;
      wait_frames("t3_timeout", f0 + 2, 600);
      tick(150);
      chk("t3_count",   frames.size(), f0 + 2);
      chk("t2_frame",   frames[f0], 8'h13);
      chk("t2_cs_low",  lows[f0], 68);
      chk("t3_frame",   frames[f0+1], 8'h1F);
      chk("t3_gap",     gaps[f0+1], GAP);
      chk("t3_applied", gain_applied, 5'h1F);
      chk("t3_done",    ud_cnt - ud0, 2);

      // 4: one idle force, then three forces inside that frame -> one extra frame
      f0 = frames.size(); ud0 = ud_cnt;
      force_update = 1'b1; tick(1); force_update = 1'b0;
      tick(15);
      repeat (3) begin
         force_update = 1'b1; tick(1); force_update = 1'b0;
         tick(7);
      end
      wait_frames("t4_timeout", f0 + 2, 600);
      tick(150);
      chk("t4_count",   frames.size(), f0 + 2);
      chk("t4_frame_a", frames[f0], 8'h1F);
      chk("t4_frame_b", frames[f0+1], 8'h1F);
      chk("t4_gap",     gaps[f0+1], GAP);
      chk("t4_done",    ud_cnt - ud0, 2);

      // 5: reset in the middle of the shift phase
      gain_code = 5'h07;
      tick(32);
      f0 = frames.size();
      reset_n = 1'b0;
      #1;
      chk("t5_cs_n",    pga_cs_n, 1);
      chk("t5_sclk",    pga_sclk, 0);
      chk("t5_mosi",    pga_mosi, 0);
      chk("t5_applied", gain_applied, 5'h00);
      chk("t5_busy",    busy, 0);
      gain_code = 5'h0C;
      tick(4);
      ud0 = ud_cnt;
      reset_n = 1'b1;
      wait_frames("t5_timeout", f0 + 1, 300);
      tick(150);
      chk("t5_count",   frames.size(), f0 + 1);
      chk("t5_frame",   frames[f0], 8'h0C);
      chk("t5_bits",    nbits[f0], 8);
      chk("t5_cs_low",  lows[f0], 68);
      chk("t5_applied", gain_applied, 5'h0C);
      chk("t5_done",    ud_cnt - ud0, 1);

`ifdef PGA_SETTLE_BLANK_EN
      // 6: settle blanking window
      f0 = frames.size(); ud0 = ud_cnt;
      gain_code = 5'h15;
      wait_frames("t6_timeout", f0 + 1, 300);
      tick(5);
      chk("t6_busy_settle",  busy, 1);
      chk("t6_blank_settle", settle_blank, 1);
      chk("t6_done_early",   ud_cnt - ud0, 0);
      tick(40);
      chk("t6_blank_len", blanks[blanks.size()-1], 78);
      chk("t6_lag",       lags[lags.size()-1], 10);
      chk("t6_applied",   gain_applied, 5'h15);
      chk("t6_done",      ud_cnt - ud0, 1);
      chk("t6_busy_end",  busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
